inst_sram_resp: RTL and testbench

INST_SRAM_RESP -- requirements
Module: inst_sram_resp

---
 rtl/inst_sram_resp_pkg.sv | 15 +
 rtl/inst_sram_resp_sram_bank.sv | 26 ++
 rtl/inst_sram_resp.sv | 114 +++++++++++
 tb/tb_inst_sram_resp.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/inst_sram_resp_pkg.sv
// Shared bus widths, FSM encoding and response constants for the instruction SRAM responder.
package inst_sram_resp_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WEN_W  = DATA_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [DATA_W-1:0] RESET_RDATA = '0;
  localparam logic [DATA_W-1:0] ERR_RDATA   = '0;

endpackage

// File: rtl/inst_sram_resp_sram_bank.sv
// DEPTH x 32 storage with per-byte write enables; synchronous write, combinational read.
module sram_bank
  import inst_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic [WEN_W-1:0]  we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WEN_W; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: clear sweep FSM, address decode and registered fetch response.
module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'hbfc00000,
  parameter logic [31:0] INIT   = 32'h0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sram_en,
  input  logic [WEN_W-1:0]  sram_wen,
  input  logic [31:0]       sram_addr,
  input  logic [DATA_W-1:0] sram_wdata,
  output logic [DATA_W-1:0] sram_rdata,
  output logic              sram_err,
  input  logic              clr,
  output logic              busy
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] idx;
  logic              hit;
  logic              err_req;
  logic              accept;
  logic              do_write;
  logic [WEN_W-1:0]  bank_we;
  logic [ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] bank_rdata;
  logic [DATA_W-1:0] merged;

  assign hit      = (sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
  assign idx      = sram_addr[ADDR_W+1:2];
  assign err_req  = sram_en && (!hit || (sram_addr[1:0] != 2'b00));
  assign accept   = (state == READY) && sram_en && !clr;
  assign do_write = accept && !err_req && (sram_wen != '0);

  // The sweep owns the bank port while clearing; requests are ignored then.
  always_comb begin
    bank_we    = '0;
    bank_addr  = idx;
    bank_wdata = sram_wdata;
    if (state == CLEAR) begin
      bank_we    = '1;
      bank_addr  = cnt;
      bank_wdata = INIT;
    end else if (do_write) begin
      bank_we = sram_wen;
    end
  end

  sram_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .addr  (bank_addr),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  // Write-first response: return the word as it will be after this edge.
  always_comb begin
    merged = bank_rdata;
    for (int unsigned i = 0; i < WEN_W; i++) begin
      if (sram_wen[i]) merged[8*i +: 8] = sram_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= CLEAR;
      cnt        <= '0;
      busy       <= 1'b1;
      sram_rdata <= RESET_RDATA;
      sram_err   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr) begin
            cnt <= '0;
          end else if (cnt == '1) begin
            cnt   <= '0;
            state <= READY;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          if (clr) begin
            cnt   <= '0;
            state <= CLEAR;
            busy  <= 1'b1;
          end else if (sram_en) begin
            if (err_req) begin
              sram_rdata <= ERR_RDATA;
              sram_err   <= 1'b1;
            end else begin
              sram_rdata <= merged;
              sram_err   <= 1'b0;
            end
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sram_resp.sv
// Directed bench for inst_sram_resp with ADDR_W=4 and a non-zero fill value.
module tb_inst_sram_resp;

  localparam logic [31:0] BASE = 32'hbfc00000;
  localparam logic [31:0] INIT = 32'h0badf00d;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_err;
  logic        clr;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  inst_sram_resp #(.ADDR_W(4), .BASE(BASE), .INIT(INIT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_err   (sram_err),
    .clr        (clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    sram_en    = 1'b1;
    sram_wen   = wen;
    sram_addr  = addr;
    sram_wdata = wdata;
    tick();
    sram_en    = 1'b0;
    sram_wen   = 4'h0;
  endtask

  task automatic busy_cycles(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    resetn = 1'b0; sram_en = 1'b0; sram_wen = 4'h0;
    sram_addr = '0; sram_wdata = '0; clr = 1'b0;
    repeat (3) tick();
    check("rst_rdata", sram_rdata, 32'h0);
    check("rst_err", {31'b0, sram_err}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h1);

    resetn = 1'b1;
    busy_cycles(n);
    check("busy_len_reset", n, 32'd16);

    req(4'h0, BASE + 32'h3c, 32'h0);
    check("rd_last_init", sram_rdata, INIT);
    check("rd_last_err", {31'b0, sram_err}, 32'h0);

    req(4'hf, BASE + 32'h8, 32'hffffffff);
    check("wr_full_resp", sram_rdata, 32'hffffffff);
    req(4'b0101, BASE + 32'h8, 32'h12345678);
    check("wr_byte_resp", sram_rdata, 32'hff34ff78);
    req(4'h0, BASE + 32'h8, 32'h0);
    check("rd_byte_merge", sram_rdata, 32'hff34ff78);

    req(4'hf, BASE + 32'h4, 32'ha5a5a5a5);
    req(4'h0, BASE + 32'h4, 32'h0);
    check("rd_hold_src", sram_rdata, 32'ha5a5a5a5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_rdata", sram_rdata, 32'ha5a5a5a5);
    end

    req(4'h0, BASE + 32'h2, 32'h0);
    check("mis_rdata", sram_rdata, 32'h0);
    check("mis_err", {31'b0, sram_err}, 32'h1);
    repeat (2) tick();
    check("err_hold", {31'b0, sram_err}, 32'h1);
    req(4'h0, 32'h00000000, 32'h0);
    check("miss_rdata", sram_rdata, 32'h0);
    check("miss_err", {31'b0, sram_err}, 32'h1);
    req(4'hf, BASE + 32'ha, 32'h11111111);
    check("mis_wr_err", {31'b0, sram_err}, 32'h1);
    req(4'hf, BASE + 32'h48, 32'h22222222);
    check("alias_wr_err", {31'b0, sram_err}, 32'h1);
    req(4'h0, BASE + 32'h8, 32'h0);
    check("err_nochange", sram_rdata, 32'hff34ff78);
    check("err_cleared", {31'b0, sram_err}, 32'h0);

    clr = 1'b1;
    req(4'hf, BASE, 32'h12345678);
    clr = 1'b0;
    check("conflict_hold", sram_rdata, 32'hff34ff78);
    check("conflict_busy", {31'b0, busy}, 32'h1);
    req(4'h0, 32'h00000000, 32'h0);
    check("clear_drop_err", {31'b0, sram_err}, 32'h0);
    check("clear_drop_rd", sram_rdata, 32'hff34ff78);
    repeat (4) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    busy_cycles(n);
    check("busy_len_restart", n, 32'd16);
    req(4'h0, BASE, 32'h0);
    check("conflict_init", sram_rdata, INIT);
    req(4'h0, BASE + 32'h8, 32'h0);
    check("clear_swept", sram_rdata, INIT);

    req(4'hf, BASE + 32'h3c, 32'h77777777);
    check("wr_last_resp", sram_rdata, 32'h77777777);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (7) tick();
    resetn = 1'b0;
    #3;
    check("abort_rdata", sram_rdata, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h1);
    resetn = 1'b1;
    busy_cycles(n);
    check("busy_len_abort", n, 32'd16);
    check("abort_rdata_after", sram_rdata, 32'h0);
    req(4'h0, BASE + 32'h3c, 32'h0);
    check("abort_swept", sram_rdata, INIT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
